// File: rtl/pla_eval_scheduler.sv
// Round-robin sequencer sharing one combinational PLA evaluator,
// with an exhaustive self-test sweep that folds outputs into a signature.
module pla_eval_scheduler #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 46,
  parameter int SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*IN_W-1:0]          req_vec,
  output logic [NREQ-1:0]               req_ready,
  output logic [IN_W-1:0]               pla_in,
  input  logic [OUT_W-1:0]              pla_out,
  output logic                          rsp_valid,
  output logic [(NREQ>1 ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [OUT_W-1:0]              rsp_data,
  input  logic                          rsp_ready,
  input  logic                          sweep_start,
  output logic                          sweep_busy,
  output logic                          sweep_done,
  output logic [OUT_W-1:0]              sweep_sig
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [IN_W:0] LAST = {1'b0, {IN_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, EVAL, RESP, SWEEP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [IN_W:0]    vcnt;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             grant_ok;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  // Sweep start wins over any request arriving in the same idle cycle.
  assign grant_ok  = (state == IDLE) && !sweep_start && found;
  assign req_ready = grant_ok ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      vcnt       <= '0;
      pla_in     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      sweep_sig  <= '0;
    end else begin
      sweep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sweep_start) begin
            sweep_sig  <= '0;
            pla_in     <= '0;
            vcnt       <= '0;
            cnt        <= CNT_LD;
            sweep_busy <= 1'b1;
            state      <= SWEEP;
          end else if (grant_ok) begin
            pla_in <= req_vec[win*IN_W +: IN_W];
            rsp_id <= win;
            rr_ptr <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
            cnt    <= CNT_LD;
            state  <= EVAL;
          end
        end
        EVAL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            rsp_data  <= pla_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        SWEEP: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            sweep_sig <= {sweep_sig[OUT_W-2:0], sweep_sig[OUT_W-1]}
                         ^ pla_out;
            if (vcnt == LAST) begin
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
              pla_in     <= '0;
              state      <= IDLE;
            end else begin
              vcnt   <= vcnt + 1'b1;
              pla_in <= vcnt[IN_W-1:0] + 1'b1;
              cnt    <= CNT_LD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
